// File: rtl/bm_dag1_inv_search.sv
// ----------------------------------------------------------------------------
// bm_dag1_inv_search
//
// Inverse search over the DAG1 benchmark function
//     f(a,b) = ((a+b) + (a-b)) - (b+b)   (every node truncated to BITS bits)
// Given a target result and the known b operand, the block walks candidate
// values of a, one per clock, and reports the lowest a that reproduces the
// target.
//
// Optional feature (macro DAG1_INV_COUNT_EN):
//   undefined : early exit on the first match; no sol_count port.
//   defined   : every candidate is tested; a_out is still the first match and
//               sol_count reports the total number of matches.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   search request, sampled only while idle
//   out_in     in   [BITS-1:0] target result
//   b_in       in   [BITS-1:0] known b operand
//   busy       out  high while a search or its done cycle is in progress
//   done       out  one-cycle pulse, results valid
//   found      out  a matching a exists
//   a_out      out  [BITS-1:0] lowest matching a (0 when none)
//   sol_count  out  [BITS:0] number of matches (DAG1_INV_COUNT_EN only)
// ----------------------------------------------------------------------------
module bm_dag1_inv_search #(
    parameter int BITS = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [BITS-1:0] out_in,
    input  logic [BITS-1:0] b_in,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic [BITS-1:0] a_out
`ifdef DAG1_INV_COUNT_EN
    ,
    output logic [BITS:0]   sol_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          r_state;
    logic [BITS-1:0] r_cand;
    logic [BITS-1:0] r_target;
    logic [BITS-1:0] r_b;
    logic            r_busy;
    logic            r_done;
    logic            r_found;
    logic [BITS-1:0] r_a;
`ifdef DAG1_INV_COUNT_EN
    logic [BITS:0]   r_count;
`endif

    // Forward DAG evaluated on the registered candidate; each node is its own
    // BITS-wide wire so the truncation happens at every intermediate.
    logic [BITS-1:0] w_sum;
    logic [BITS-1:0] w_diff;
    logic [BITS-1:0] w_bb;
    logic [BITS-1:0] w_left;
    logic [BITS-1:0] w_f;
    logic            w_match;
    logic            w_last;

    assign w_sum   = r_cand + r_b;
    assign w_diff  = r_cand - r_b;
    assign w_bb    = r_b + r_b;
    assign w_left  = w_sum + w_diff;
    assign w_f     = w_left - w_bb;
    assign w_match = (w_f == r_target);
    // Final candidate: the search ends here so cand never wraps to 0.
    assign w_last  = (r_cand == {BITS{1'b1}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cand   <= '0;
            r_target <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_a      <= '0;
`ifdef DAG1_INV_COUNT_EN
            r_count  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SEARCH;
                        r_target <= out_in;
                        r_b      <= b_in;
                        r_cand   <= '0;
                        r_found  <= 1'b0;
                        r_a      <= '0;
                        r_busy   <= 1'b1;
`ifdef DAG1_INV_COUNT_EN
                        r_count  <= '0;
`endif
                    end
                end
                SEARCH: begin
`ifdef DAG1_INV_COUNT_EN
                    if (w_match) begin
                        // Keep the first (lowest) match, count all of them.
                        if (!r_found) begin
                            r_found <= 1'b1;
                            r_a     <= r_cand;
                        end
                        r_count <= r_count + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cand  <= r_cand + 1'b1;
                    end
`else
                    if (w_match) begin
                        r_found <= 1'b1;
                        r_a     <= r_cand;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (w_last) begin
                        // Exhausted without a match: found/a_out stay cleared.
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cand  <= r_cand + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign found = r_found;
    assign a_out = r_a;
`ifdef DAG1_INV_COUNT_EN
    assign sol_count = r_count;
`endif

endmodule

// File: tb/tb_bm_dag1_inv_search.sv
// ----------------------------------------------------------------------------
// tb_bm_dag1_inv_search
//
// Scoreboard bench: each accepted search pushes its expected outcome (found,
// first a, match count, done latency) computed from f = 2a - 2b mod 2^BITS;
// a monitor pops and compares whenever done is seen.
// ----------------------------------------------------------------------------
module tb_bm_dag1_inv_search;

    localparam int BITS = 2;
    localparam int M    = 1 << BITS;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b0;
    logic            start   = 1'b0;
    logic [BITS-1:0] out_in  = '0;
    logic [BITS-1:0] b_in    = '0;
    logic            busy;
    logic            done;
    logic            found;
    logic [BITS-1:0] a_out;
`ifdef DAG1_INV_COUNT_EN
    logic [BITS:0]   sol_count;
`endif

    bm_dag1_inv_search #(.BITS(BITS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .out_in    (out_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .a_out     (a_out)
`ifdef DAG1_INV_COUNT_EN
        ,
        .sol_count (sol_count)
`endif
    );

    typedef struct {
        int found;
        int a;
        int cnt;
        int lat;
        int sc;
        int t;
        int b;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   errs  = 0;
    int   cyc   = 0;
    int   last_found = 0;
    int   last_a     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        tests++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: f reduces to 2a - 2b modulo 2^BITS.
    function automatic exp_t model(int t, int b, int sc);
        exp_t e;
        e.found = 0; e.a = 0; e.cnt = 0; e.sc = sc; e.t = t; e.b = b;
        for (int a = 0; a < M; a++) begin
            if ((((2 * a - 2 * b) % M) + M) % M == t) begin
                if (e.found == 0) begin
                    e.found = 1;
                    e.a     = a;
                end
                e.cnt++;
            end
        end
`ifdef DAG1_INV_COUNT_EN
        e.lat = M + 1;
`else
        e.lat = (e.found != 0) ? e.a + 2 : M + 1;
`endif
        return e;
    endfunction

    // Monitor
    exp_t m_e;
    logic prev_done = 1'b0;
    always @(negedge clock) begin
        if (reset_n) begin
            if (done) begin
                chk("busy_with_done", int'(busy), 1);
                if (sb.size() == 0) begin
                    tests++;
                    errs++;
                    $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
                end else begin
                    m_e = sb.pop_front();
                    $display("[TB] search t=%0d b=%0d -> found=%0d a=%0d lat=%0d", m_e.t, m_e.b,
                             found, a_out, cyc - m_e.sc);
                    chk("found", int'(found), m_e.found);
                    chk("a_out", int'(a_out), m_e.a);
                    chk("latency", cyc - m_e.sc, m_e.lat);
`ifdef DAG1_INV_COUNT_EN
                    chk("sol_count", int'(sol_count), m_e.cnt);
`endif
                end
            end
            if (done && prev_done) begin
                tests++;
                errs++;
                $display("FAIL done_width: got done high 2 cycles, expected 1 (cycle %0d)", cyc);
            end
        end
        prev_done <= done;
    end

    task automatic run(int t, int b, bit restart);
        exp_t e;
        int   i;
        @(negedge clock);
        out_in = BITS'(t);
        b_in   = BITS'(b);
        start  = 1'b1;
        e = model(t, b, cyc);
        sb.push_back(e);
        @(posedge clock);
        #1;
        start  = 1'b0;
        out_in = BITS'($urandom);   // must be ignored after the latch edge
        b_in   = BITS'($urandom);
        @(negedge clock);
        chk("busy_search", int'(busy), 1);
        if (restart) begin
            @(negedge clock);       // cycle 2 of the search
            out_in = BITS'(1);
            start  = 1'b1;
            @(posedge clock);
            #1;
            start  = 1'b0;
        end
        i = 0;
        while (sb.size() != 0 && i < M + 8) begin
            @(negedge clock);
            #1;
            i++;
        end
        if (sb.size() != 0) begin
            tests++;
            errs++;
            $display("FAIL timeout: got no done within %0d cycles, expected done", M + 8);
            sb.delete();
        end
        last_found = e.found;
        last_a     = e.a;
        // Results must hold in IDLE.
        repeat (2) @(negedge clock);
        chk("busy_idle", int'(busy), 0);
        chk("hold_found", int'(found), last_found);
        chk("hold_a_out", int'(a_out), last_a);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_a_out", int'(a_out), 0);
`ifdef DAG1_INV_COUNT_EN
        chk("rst_sol_count", int'(sol_count), 0);
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Directed cases
        run(2, 0, 1'b0);       // a=1, done at cycle 3
        run(1, 0, 1'b0);       // no match, done at cycle M+1
        run(2, 3, 1'b0);       // match on candidate 0
        run(0, 3, 1'b0);       // two matches (a=1,3)
        run(2, 0, 1'b1);       // second start during SEARCH ignored

        // Reset while idle with found=1 held
        run(2, 0, 1'b0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("idle_rst_found", int'(found), 0);
        chk("idle_rst_a_out", int'(a_out), 0);
        chk("idle_rst_busy", int'(busy), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset in the middle of a search (cycle 2)
        @(negedge clock);
        out_in = BITS'(1);
        b_in   = '0;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_found", int'(found), 0);
        chk("mid_rst_a_out", int'(a_out), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (M + 3) @(negedge clock);   // an aborted search must not finish
        run(0, 1, 1'b0);       // a=1, done at cycle 3

        // Randomized searches
        for (int n = 0; n < 40; n++) begin
            run(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
